// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bus: ID-stage redirect requests in, fetch address and redirect status out.
// master = ID/hazard side driving requests, slave = the sequencer.
interface pc_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic [WIDTH-1:0] id_pc_plus4;
    logic             branch_req;
    logic [15:0]      branch_off;
    logic             jump_req;
    logic [25:0]      jump_idx;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             flush_if;
    logic             redirect_pending;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output stall, id_pc_plus4, branch_req, branch_off, jump_req, jump_idx,
        input  pc, pc_plus4, flush_if, redirect_pending, redirect_cnt
    );

    modport slave (
        input  stall, id_pc_plus4, branch_req, branch_off, jump_req, jump_idx,
        output pc, pc_plus4, flush_if, redirect_pending, redirect_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC register: chooses PC+4 / branch / jump each cycle, parks redirects seen under stall.
// Redirect visible on pc one cycle after it applies; BRANCH_DELAY_SLOT_EN keeps flush_if at 0.
module pc_sequencer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic FLUSH_ON_REDIRECT = 1'b0;
`else
    localparam logic FLUSH_ON_REDIRECT = 1'b1;
`endif

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] br_tgt, jmp_tgt, req_tgt;
    logic             req;
    logic             apply;

    assign br_tgt  = bus.id_pc_plus4 + {{(WIDTH-18){bus.branch_off[15]}}, bus.branch_off, 2'b00};
    assign jmp_tgt = {bus.id_pc_plus4[WIDTH-1:28], bus.jump_idx, 2'b00};
    assign req     = bus.jump_req | bus.branch_req;
    assign req_tgt = bus.jump_req ? jmp_tgt : br_tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.stall && req) state_d = PEND;
            PEND:    if (!bus.stall)       state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Requests seen while parked are the same frozen ID instruction, so PEND ignores them.
    always_comb begin
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        flush_d = 1'b0;
        cnt_d   = cnt_q;
        apply   = 1'b0;
        case (state_q)
            RUN: begin
                if (!bus.stall) begin
                    if (req) begin
                        pc_d  = req_tgt;
                        apply = 1'b1;
                    end else begin
                        pc_d  = pc_q + WIDTH'(4);
                    end
                end else if (req) begin
                    tgt_d = req_tgt;
                end
            end
            PEND: begin
                if (!bus.stall) begin
                    pc_d  = tgt_q;
                    apply = 1'b1;
                end
            end
            default: ;
        endcase
        if (apply) begin
            flush_d = FLUSH_ON_REDIRECT;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.pc_plus4         = pc_q + WIDTH'(4);
    assign bus.flush_if         = flush_q;
    assign bus.redirect_pending = (state_q == PEND);
    assign bus.redirect_cnt     = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded random/directed bench for pc_sequencer against a behavioural next-PC model.
module tb_pc_sequencer;
    localparam int          W      = 32;
    localparam int          CW     = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    pc_sequencer #(.WIDTH(W), .RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        pend;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: architectural view (current PC, parked target, redirect tally)
    logic [31:0] m_pc   = RST_PC;
    logic [31:0] m_tgt  = 32'h0;
    bit          m_pend = 1'b0;
    bit          m_flush = 1'b0;
    int          m_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit s, input bit br, input bit jr, input logic [15:0] off,
                        input logic [25:0] idx, input logic [31:0] idpc, input bit rn);
        logic [31:0] bt, jt, t;
        exp_t e;
        bus.stall       = s;
        bus.branch_req  = br;
        bus.jump_req    = jr;
        bus.branch_off  = off;
        bus.jump_idx    = idx;
        bus.id_pc_plus4 = idpc;
        rst_n           = rn;
        bt = 32'(longint'(idpc) + longint'($signed(off)) * 4);
        jt = (idpc & 32'hF000_0000) | (32'(idx) * 4);
        t  = jr ? jt : bt;
        m_flush = 1'b0;
        if (!rn) begin
            m_pc = RST_PC; m_tgt = 32'h0; m_pend = 1'b0; m_cnt = 0;
        end else if (m_pend) begin
            if (!s) begin
                m_pc = m_tgt; m_pend = 1'b0; m_flush = !DS;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
        end else if (!s) begin
            if (br || jr) begin
                m_pc = t; m_flush = !DS;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else if (br || jr) begin
            m_tgt = t; m_pend = 1'b1;
        end
        e.pc = m_pc; e.flush = m_flush; e.pend = m_pend; e.cnt = m_cnt;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input bit s);
        step(s, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",               bus.pc,                     e.pc);
                check("pc_plus4",         bus.pc_plus4,               e.pc + 32'd4);
                check("flush_if",         32'(bus.flush_if),          32'(e.flush));
                check("redirect_pending", 32'(bus.redirect_pending),  32'(e.pend));
                check("redirect_cnt",     32'(bus.redirect_cnt),      32'(e.cnt));
            end
        end
    end

    initial begin : driver
        // Reset then free-running
        step(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        repeat (3) idle(1'b0);
        // Backward branch
        step(1'b0, 1'b1, 1'b0, 16'hFFFE, 26'h0, 32'h0000_0010, 1'b1);
        idle(1'b0);
        // Jump beats branch
        step(1'b0, 1'b1, 1'b1, 16'h0004, 26'h000_0100, 32'h4000_0004, 1'b1);
        idle(1'b0);
        // Jump arriving under a 3-cycle stall
        step(1'b1, 1'b0, 1'b1, 16'h0, 26'h10, 32'h0000_0000, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        // Parked redirect discarded by reset asserted mid-stall
        step(1'b1, 1'b1, 1'b0, 16'h0100, 26'h0, 32'h0000_1000, 1'b1);
        idle(1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pc",      bus.pc,                    RST_PC);
        check("async_rst_pending", 32'(bus.redirect_pending), 32'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        repeat (3) idle(1'b0);
        // Saturate the counter, then wrap-around branch
        for (int i = 0; i < 18; i++)
            step(1'b0, 1'b1, 1'b0, 16'(i), 26'h0, 32'(i * 64), 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'h0001, 26'h0, 32'hFFFF_FFFC, 1'b1);
        idle(1'b0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 15), 16'($urandom), 26'($urandom),
                 $urandom, ($urandom_range(0, 99) >= 2));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch PC register of the MIPS pipeline and decides the next PC every cycle: sequential (PC+4), branch target, or jump target.
- Sign-extends and word-shifts (<<2) branch offsets and jump indices internally.
- Holds redirects that arrive during a stall until the stall clears.
- Generates the IF flush and a saturating redirect counter.
- Sits between the ID-stage branch/jump decision logic and the instruction memory address port.

Parameters:
- WIDTH, 32, PC/address width in bits (minimum 32).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the redirect counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit stall; freezes the PC.
- id_pc_plus4  in  WIDTH  PC+4 of the instruction currently in ID; base for targets.
- branch_req  in  1  ID has resolved a taken branch this cycle.
- branch_off  in  16  raw I-type immediate of the branch.
- jump_req  in  1  ID holds a J/JAL this cycle.
- jump_idx  in  26  raw J-type index field.
- pc  out  WIDTH  current fetch address (registered).
- pc_plus4  out  WIDTH  pc + 4 (combinational from pc).
- flush_if  out  1  kill the instruction currently in IF (registered).
- redirect_pending  out  1  a redirect is latched, waiting for stall to drop.
- redirect_cnt  out  CNT_W  number of redirects applied, saturating.

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, flush_if=0, redirect_pending=0, redirect_cnt=0, state=RUN, pending target=0.
- Branch target: id_pc_plus4 + ({{(WIDTH-18){branch_off[15]}}, branch_off, 2'b00}), modulo 2^WIDTH. Wrap-around is silent.
- Jump target: {id_pc_plus4[WIDTH-1:28], jump_idx, 2'b00}.
- Request priority: jump_req over branch_req when both are high. Target selection is combinational in the request cycle.
- States:
  - RUN:
    - stall=0, no request: pc<=pc+4, flush_if<=0.
    - stall=0, request: pc<=target; flush_if<=1 (subject to optional feature); redirect_cnt++.
    - stall=1, no request: pc holds; flush_if<=0.
    - stall=1, request: latch target into the pending register; redirect_pending<=1; pc holds; go to PEND.
  - PEND:
    - New branch_req/jump_req are ignored. ID is frozen, so any repeat is the same request.
    - stall=1: hold everything.
    - stall=0: pc<=pending target; flush_if<=1 (subject to optional feature); redirect_cnt++; redirect_pending<=0; go to RUN.
- Latency:
  - Redirect in RUN with stall=0: target visible on pc one cycle after the request.
  - Redirect under stall: target visible one cycle after the first cycle with stall=0.
- flush_if: a one-cycle pulse, asserted in the cycle where pc first shows the redirect target.
- redirect_cnt: increments by 1 per applied redirect; holds at all-ones (no wrap).
- Reset asserted mid-PEND: pending target is discarded, outputs return to reset values immediately, state=RUN.
- pc[1:0] is always 2'b00 provided RESET_PC is word-aligned. Branch and jump targets are word-aligned by construction.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined: MIPS delay-slot semantics. The instruction in IF at redirect time (the delay slot) is kept; flush_if stays 0 at all times.
- Undefined: flush_if pulses for one cycle on every applied redirect, as described in Behaviour.
- pc sequencing, redirect_pending and redirect_cnt behave identically in both builds.

Test Plan:
- Reset then 3 free-running cycles, stall=0 -> pc = 0x0, 0x4, 0x8, 0xC; flush_if=0; redirect_cnt=0.
- branch_req=1, id_pc_plus4=0x0000_0010, branch_off=16'hFFFE, stall=0 -> next cycle pc=0x0000_0008, flush_if=1 for exactly one cycle (0 with BRANCH_DELAY_SLOT_EN), redirect_cnt=1.
- jump_req=1 and branch_req=1 together, id_pc_plus4=0x4000_0004, jump_idx=26'h000_0100, branch_off=0x0004 -> pc=0x4000_0400 (jump wins).
- stall=1 for 3 cycles with jump_req pulsed in cycle 1, jump_idx=26'h10 -> pc frozen and redirect_pending=1 for cycles 2-3; first cycle after stall=0, pc=0x40 (upper nibble from id_pc_plus4=0x0...), redirect_pending=0.
- Redirect latched in PEND, then rst_n pulsed low mid-stall -> pc=RESET_PC immediately, redirect_pending=0; after release, pc increments from RESET_PC with no redirect applied.
- Force redirect_cnt to all-ones (CNT_W=4, 16 redirects) -> value stays 4'hF on further redirects; id_pc_plus4=0xFFFF_FFFC with branch_off=0x0001 -> pc=0x0000_0000 (wrap).
